// File: rtl/flappy_pkg.sv
// Shared game constants: FSM encoding, life width, defaults.
// Used by the life manager and the icon renderer.
package flappy_pkg;

  localparam int LIFE_W          = 4;
  localparam int TMR_W           = 8;
  localparam int DEF_INIT_LIVES  = 3;
  localparam int DEF_MAX_LIVES   = 9;
  localparam int ICON_PX         = 16;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PLAY      = 3'd1,
    ST_FREEZE    = 3'd2,
    ST_INVULN    = 3'd3,
    ST_GAME_OVER = 3'd4
  } state_e;

  function automatic logic [LIFE_W-1:0] sat_inc(
    input logic [LIFE_W-1:0] v,
    input logic [LIFE_W-1:0] mx
  );
    return (v >= mx) ? mx : v + 1'b1;
  endfunction

endpackage

// File: rtl/frame_timer.sv
// 8-bit loadable frame down-counter; expire flags the
// tick that takes it from 1 to 0.
module frame_timer
  import flappy_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_tick,
  input  logic             pause,
  input  logic             load,
  input  logic             clear,
  input  logic [TMR_W-1:0] load_val,
  output logic             expire
);

  logic [TMR_W-1:0] cnt_q;
  logic             tick_en;

  assign tick_en = frame_tick & ~pause;
  assign expire  = tick_en & (cnt_q == TMR_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (tick_en && cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/life_manager.sv
// Life count owner: hit -> freeze -> blink -> play cycle,
// game over, and frame-synchronous life icon count.
module life_manager
  import flappy_pkg::*;
#(
  parameter int INIT_LIVES     = DEF_INIT_LIVES,
  parameter int MAX_LIVES      = DEF_MAX_LIVES,
  parameter int RESPAWN_FRAMES = 60,
  parameter int INVULN_FRAMES  = 120,
  parameter int BLINK_FRAMES   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_tick,
  input  logic              game_start,
  input  logic              hit,
  input  logic              bonus,
  input  logic              pause,
  output logic [LIFE_W-1:0] life_number,
  output logic              bird_visible,
  output logic              invulnerable,
  output logic              respawn_req,
  output logic              game_over,
  output logic [2:0]        state
);

  localparam logic [LIFE_W-1:0] INIT_L = LIFE_W'(INIT_LIVES);
  localparam logic [LIFE_W-1:0] MAX_L  = LIFE_W'(MAX_LIVES);
  localparam logic [TMR_W-1:0]  RESP_F = TMR_W'(RESPAWN_FRAMES);
  localparam logic [TMR_W-1:0]  INV_F  = TMR_W'(INVULN_FRAMES);
  localparam logic [TMR_W-1:0]  BLK_F  = TMR_W'(BLINK_FRAMES);

  state_e            state_q, state_d;
  logic [LIFE_W-1:0] lives_q, lives_d;
  logic [LIFE_W-1:0] life_num_q;
  logic              vis_q, vis_d;
  logic              resp_q, resp_d;
  logic              hit_q;

  logic             hit_rise, bonus_v;
  logic             m_load, m_exp, b_load, b_exp, t_clr;
  logic [TMR_W-1:0] m_val;

  // pause discards events but hit_q keeps tracking below
  assign hit_rise = hit & ~hit_q & ~pause;
  assign bonus_v  = bonus & ~pause;

  frame_timer u_main (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_tick (frame_tick),
    .pause      (pause),
    .load       (m_load),
    .clear      (t_clr),
    .load_val   (m_val),
    .expire     (m_exp)
  );

  frame_timer u_blink (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_tick (frame_tick),
    .pause      (pause),
    .load       (b_load),
    .clear      (t_clr),
    .load_val   (BLK_F),
    .expire     (b_exp)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    lives_d = lives_q;
    vis_d   = vis_q;
    resp_d  = 1'b0;
    m_load  = 1'b0;
    m_val   = RESP_F;
    b_load  = 1'b0;
    t_clr   = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_GAME_OVER: begin
        vis_d = 1'b1;
        if (game_start) begin
          state_d = ST_PLAY;
          lives_d = INIT_L;
          t_clr   = 1'b1;
        end
      end
      ST_PLAY: begin
        if (hit_rise) begin
          lives_d = bonus_v ? lives_q : lives_q - 1'b1;
          if (lives_d == '0) begin
            state_d = ST_GAME_OVER;
          end else begin
            state_d = ST_FREEZE;
            m_load  = 1'b1;
          end
        end else if (bonus_v) begin
          lives_d = sat_inc(lives_q, MAX_L);
        end
      end
      ST_FREEZE: begin
        if (bonus_v) lives_d = sat_inc(lives_q, MAX_L);
        if (m_exp) begin
          state_d = ST_INVULN;
          m_load  = 1'b1;
          m_val   = INV_F;
          b_load  = 1'b1;
          resp_d  = 1'b1;
        end
      end
      ST_INVULN: begin
        if (bonus_v) lives_d = sat_inc(lives_q, MAX_L);
        if (m_exp) begin
          state_d = ST_PLAY;
          vis_d   = 1'b1;
          t_clr   = 1'b1;
        end else if (b_exp) begin
          vis_d  = ~vis_q;
          b_load = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lives_q    <= INIT_L;
      life_num_q <= INIT_L;
      vis_q      <= 1'b1;
      resp_q     <= 1'b0;
      hit_q      <= 1'b0;
    end else begin
      lives_q <= lives_d;
      vis_q   <= vis_d;
      resp_q  <= resp_d;
      hit_q   <= hit;
      // GAME_OVER holds lives at 0, so the row blanks on the next tick
      if (frame_tick) life_num_q <= lives_q;
    end
  end

  always_comb begin
    life_number  = life_num_q;
    bird_visible = vis_q;
    respawn_req  = resp_q;
    invulnerable = (state_q == ST_FREEZE) || (state_q == ST_INVULN);
    game_over    = (state_q == ST_GAME_OVER);
    state        = state_q;
  end

endmodule

// File: tb/tb_life_manager.sv
// Directed bench for life_manager with default parameters.
// Vectors walk the hit/freeze/blink cycle, pause, bonus and reset.
module tb_life_manager;

  logic       clk = 1'b0;
  logic       rst_n, frame_tick, game_start, hit, bonus, pause;
  logic [3:0] life_number;
  logic       bird_visible, invulnerable, respawn_req, game_over;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;

  life_manager dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .frame_tick   (frame_tick),
    .game_start   (game_start),
    .hit          (hit),
    .bonus        (bonus),
    .pause        (pause),
    .life_number  (life_number),
    .bird_visible (bird_visible),
    .invulnerable (invulnerable),
    .respawn_req  (respawn_req),
    .game_over    (game_over),
    .state        (state)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      cyc();
      frame_tick = 1'b0;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  initial begin
    rst_n = 1'b0; frame_tick = 1'b0; game_start = 1'b0;
    hit = 1'b0; bonus = 1'b0; pause = 1'b0;
    cyc(); cyc();
    chk("rst_state", 8'(state), 8'd0);
    chk("rst_life", 8'(life_number), 8'd3);
    chk("rst_vis", 8'(bird_visible), 8'd1);
    chk("rst_inv", 8'(invulnerable), 8'd0);
    chk("rst_resp", 8'(respawn_req), 8'd0);
    chk("rst_go", 8'(game_over), 8'd0);
    rst_n = 1'b1;
    cyc();

    game_start = 1'b1; cyc(); game_start = 1'b0;
    chk("start_state", 8'(state), 8'd1);
    tick(1);
    chk("start_life", 8'(life_number), 8'd3);
    chk("start_vis", 8'(bird_visible), 8'd1);

    hit = 1'b1; cyc();
    chk("hit1_state", 8'(state), 8'd2);
    chk("hit1_inv", 8'(invulnerable), 8'd1);
    tick(1);
    chk("hit1_life", 8'(life_number), 8'd2);
    tick(58);
    chk("freeze59", 8'(state), 8'd2);
    chk("freeze59_resp", 8'(respawn_req), 8'd0);
    tick(1);
    chk("respawn_pulse", 8'(respawn_req), 8'd1);
    chk("invuln_state", 8'(state), 8'd3);
    cyc();
    chk("respawn_end", 8'(respawn_req), 8'd0);
    tick(7);
    chk("blink7", 8'(bird_visible), 8'd1);
    tick(1);
    chk("blink8", 8'(bird_visible), 8'd0);
    tick(8);
    chk("blink16", 8'(bird_visible), 8'd1);
    tick(88);
    chk("blink104", 8'(bird_visible), 8'd0);
    tick(15);
    chk("inv119_state", 8'(state), 8'd3);
    chk("inv119_vis", 8'(bird_visible), 8'd1);
    tick(1);
    chk("inv_done_state", 8'(state), 8'd1);
    chk("inv_done_vis", 8'(bird_visible), 8'd1);
    chk("inv_done_inv", 8'(invulnerable), 8'd0);

    hit = 1'b0; cyc(); hit = 1'b1; cyc();
    chk("hit2_state", 8'(state), 8'd2);
    tick(1);
    chk("hit2_life", 8'(life_number), 8'd1);

    pause = 1'b1;
    tick(100);
    hit = 1'b0; cyc(); hit = 1'b1; cyc();
    bonus = 1'b1; cyc(); bonus = 1'b0;
    chk("pause_state", 8'(state), 8'd2);
    pause = 1'b0; cyc();
    tick(1);
    chk("pause_life", 8'(life_number), 8'd1);
    tick(57);
    chk("pause_timer_hold", 8'(state), 8'd2);
    tick(1);
    chk("pause_timer_exp", 8'(state), 8'd3);
    hit = 1'b0;
    tick(120);
    chk("back_play", 8'(state), 8'd1);

    hit = 1'b1; bonus = 1'b1; cyc(); bonus = 1'b0;
    chk("hitbonus_state", 8'(state), 8'd2);
    tick(1);
    chk("hitbonus_life", 8'(life_number), 8'd1);
    tick(59);
    chk("hb_invuln", 8'(state), 8'd3);
    tick(120);
    chk("hb_play", 8'(state), 8'd1);
    hit = 1'b0; cyc(); hit = 1'b1; cyc();
    chk("go_state", 8'(state), 8'd4);
    chk("go_flag", 8'(game_over), 8'd1);
    tick(1);
    chk("go_life", 8'(life_number), 8'd0);
    chk("go_vis", 8'(bird_visible), 8'd1);

    hit = 1'b0; cyc();
    hit = 1'b1; game_start = 1'b1; cyc(); game_start = 1'b0;
    chk("restart_state", 8'(state), 8'd1);
    chk("restart_go", 8'(game_over), 8'd0);
    tick(1);
    chk("restart_life", 8'(life_number), 8'd3);
    hit = 1'b0; cyc();

    for (int i = 0; i < 10; i++) begin
      bonus = 1'b1; cyc(); bonus = 1'b0; cyc();
    end
    tick(1);
    chk("bonus_sat", 8'(life_number), 8'd9);

    hit = 1'b1; cyc(); hit = 1'b0;
    tick(60);
    chk("pre_rst_state", 8'(state), 8'd3);
    tick(8);
    chk("pre_rst_vis", 8'(bird_visible), 8'd0);
    chk("pre_rst_life", 8'(life_number), 8'd8);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_state", 8'(state), 8'd0);
    chk("arst_life", 8'(life_number), 8'd3);
    chk("arst_vis", 8'(bird_visible), 8'd1);
    chk("arst_inv", 8'(invulnerable), 8'd0);
    chk("arst_go", 8'(game_over), 8'd0);
    chk("arst_resp", 8'(respawn_req), 8'd0);
    cyc();
    rst_n = 1'b1;
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
